// File: rtl/lfsr_axil_pkg.sv
// Shared constants for the LFSR AXI4-Lite register file: word indices of the
// register map (byte address bits [3:2]), response codes and CTRL bit positions.
package lfsr_axil_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_SEED = 2'd1;
    localparam logic [1:0] ADDR_TAPS = 2'd2;
    localparam logic [1:0] ADDR_OUT  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;

endpackage

// File: rtl/lfsr_axil_regs.sv
// AXI4-Lite register file holding start/stop/seed/taps for one 8-bit LFSR and
// returning the live LFSR state. One outstanding write, one outstanding read.
module lfsr_axil_regs
    import lfsr_axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = 4,
    parameter int          DATA_WIDTH = 32,
    parameter logic [7:0]  SEED_RST   = 8'h01,
    parameter logic [7:0]  TAPS_RST   = 8'hB8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic                    lfsr_start,
    output logic                    lfsr_stop,
    output logic [7:0]              lfsr_seed,
    output logic [7:0]              lfsr_taps,
    input  logic [7:0]              lfsr_out
);

    logic                  ready_en;
    logic                  aw_held;
    logic                  w_held;
    logic [1:0]            aw_idx;
    logic [7:0]            wdata_q;
    logic                  wstrb0_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            ctrl_q;
    logic [7:0]            seed_q;
    logic [7:0]            taps_q;
    logic [7:0]            rd_byte;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  commit;
    logic                  unused_bits;

    // ready_en keeps every ready low while reset is applied and for the first cycle after
    assign s_axil_awready = ready_en && !aw_held && !bvalid_q;
    assign s_axil_wready  = ready_en && !w_held && !bvalid_q;
    assign s_axil_arready = ready_en && !rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

    assign aw_fire = s_axil_awvalid && s_axil_awready;
    assign w_fire  = s_axil_wvalid && s_axil_wready;
    assign ar_fire = s_axil_arvalid && s_axil_arready;
    assign commit  = aw_held && w_held;

    assign lfsr_start = ctrl_q[CTRL_START];
    assign lfsr_stop  = ctrl_q[CTRL_STOP];
    assign lfsr_seed  = seed_q;
    assign lfsr_taps  = taps_q;

    assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0],
                           s_axil_wdata[DATA_WIDTH-1:8], s_axil_wstrb[DATA_WIDTH/8-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= 2'd0;
            wdata_q  <= 8'h00;
            wstrb0_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            ctrl_q   <= 2'b00;
            seed_q   <= SEED_RST;
            taps_q   <= TAPS_RST;
        end else begin
            ready_en <= 1'b1;
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axil_awaddr[3:2];
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                wdata_q  <= s_axil_wdata[7:0];
                wstrb0_q <= s_axil_wstrb[0];
            end
            // Both halves present: apply the write and open the response
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= (aw_idx == ADDR_OUT) ? RESP_SLVERR : RESP_OKAY;
                if (wstrb0_q) begin
                    case (aw_idx)
                        ADDR_CTRL: ctrl_q <= wdata_q[1:0];
                        ADDR_SEED: seed_q <= wdata_q;
                        ADDR_TAPS: taps_q <= wdata_q;
                        default:   ;
                    endcase
                end
            end else if (bvalid_q && s_axil_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (s_axil_araddr[3:2])
            ADDR_CTRL: rd_byte = {6'b000000, ctrl_q};
            ADDR_SEED: rd_byte = seed_q;
            ADDR_TAPS: rd_byte = taps_q;
            default:   rd_byte = lfsr_out;
        endcase
    end

    // Read data is captured at the AR handshake and held until rready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= {{(DATA_WIDTH-8){1'b0}}, rd_byte};
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_axil_regs.sv
// Bench for lfsr_axil_regs: directed register-map scenarios, then random
// reads/writes against a register-array reference model. A small LFSR drives lfsr_out.
module tb_lfsr_axil_regs;
    import lfsr_axil_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [3:0]  s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic        lfsr_start;
    logic        lfsr_stop;
    logic [7:0]  lfsr_seed;
    logic [7:0]  lfsr_taps;
    logic [7:0]  lfsr_out;

    lfsr_axil_regs #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .SEED_RST(8'h01), .TAPS_RST(8'hB8)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .lfsr_start(lfsr_start), .lfsr_stop(lfsr_stop), .lfsr_seed(lfsr_seed),
        .lfsr_taps(lfsr_taps), .lfsr_out(lfsr_out)
    );

    always #5 clk = ~clk;

    // Stand-in LFSR core: holds the seed unless started and not stopped
    logic [7:0] lfsr_state = 8'h00;
    assign lfsr_out = lfsr_state;
    always @(posedge clk) begin
        if (lfsr_stop || !lfsr_start) lfsr_state <= lfsr_seed;
        else                          lfsr_state <= {lfsr_state[6:0], ^(lfsr_state & lfsr_taps)};
    end

    int passed = 0;
    int total  = 0;
    logic [7:0] m_reg [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_reg[0] = 8'h00; m_reg[1] = 8'h01; m_reg[2] = 8'hB8; m_reg[3] = 8'h00;
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (strb[0] && idx != 3) m_reg[idx] = data[7:0] & ((idx == 0) ? 8'h03 : 8'hFF);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit lead, input bit hold, output logic [1:0] resp, output int lat);
        int  cnt;
        logic aw_go, w_go;
        cnt = 0;
        s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
        s_axil_awvalid = 1'b1; s_axil_wvalid = !lead;
        while ((s_axil_awvalid || s_axil_wvalid) && cnt < 50) begin
            aw_go = s_axil_awvalid && s_axil_awready;
            w_go  = s_axil_wvalid && s_axil_wready;
            @(posedge clk); #1; cnt++;
            if (aw_go) begin
                s_axil_awvalid = 1'b0;
                if (lead) s_axil_wvalid = 1'b1;
            end
            if (w_go) s_axil_wvalid = 1'b0;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        lat = 0;
        while (!s_axil_bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        check("b_arrives", {31'b0, s_axil_bvalid}, 32'd1);
        resp = s_axil_bresp;
        if (!hold) begin
            s_axil_bready = 1'b1; @(posedge clk); #1; s_axil_bready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output logic [7:0] out_hs);
        int cnt;
        cnt = 0;
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        while (!s_axil_arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        out_hs = lfsr_out;
        @(posedge clk); #1; s_axil_arvalid = 1'b0;
        while (!s_axil_rvalid && cnt < 100) begin @(posedge clk); #1; cnt++; end
        check("r_arrives", {31'b0, s_axil_rvalid}, 32'd1);
        data = s_axil_rdata; resp = s_axil_rresp;
        s_axil_rready = 1'b1; @(posedge clk); #1; s_axil_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, d1, d2, d0;
        logic [1:0]  r;
        logic [7:0]  o, o1, o2;
        int          lat, cnt, idx;
        logic [3:0]  a, s;
        logic [31:0] wd;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_readys", {29'b0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'd0);
        check("rst_valids", {30'b0, s_axil_bvalid, s_axil_rvalid}, 32'd0);
        check("rst_resps", {28'b0, s_axil_bresp, s_axil_rresp}, 32'd0);
        check("rst_rdata", s_axil_rdata, 32'd0);
        check("rst_outputs", {14'b0, lfsr_stop, lfsr_start, lfsr_seed, lfsr_taps}, {18'b0, 8'h01, 8'hB8});
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset values through the bus
        for (int i = 0; i < 3; i++) begin
            do_read(4'(i * 4), d, r, o);
            check("rst_read", d, {24'b0, m_reg[i]});
            check("rst_rresp", {30'b0, r}, 32'd0);
        end

        // AW one cycle ahead of W
        do_write(4'h4, 32'h0000_00A5, 4'hF, 1'b1, 1'b0, r, lat);
        model_write(4'h4, 32'hA5, 4'hF);
        check("seed_bresp", {30'b0, r}, 32'd0);
        check("seed_b_latency", lat, 32'd1);
        check("seed_out", {24'b0, lfsr_seed}, 32'h0000_00A5);

        // Start the LFSR and watch it move, then stop it
        do_write(4'h0, 32'h1, 4'hF, 1'b0, 1'b0, r, lat);
        model_write(4'h0, 32'h1, 4'hF);
        check("start_level", {30'b0, lfsr_stop, lfsr_start}, 32'd1);
        do_read(4'hC, d1, r, o1);
        check("out_read1", d1, {24'b0, o1});
        do_read(4'hC, d2, r, o2);
        check("out_read2", d2, {24'b0, o2});
        check("out_running", {31'b0, d1 != d2}, 32'd1);
        do_write(4'h0, 32'h2, 4'hF, 1'b0, 1'b0, r, lat);
        model_write(4'h0, 32'h2, 4'hF);
        do_read(4'hC, d, r, o);
        check("out_stopped_seed", d, 32'h0000_00A5);

        // Write to the read-only OUT register, and a strobe-less TAPS write
        do_write(4'hC, 32'h55, 4'hF, 1'b0, 1'b0, r, lat);
        check("out_wr_slverr", {30'b0, r}, {30'b0, RESP_SLVERR});
        do_read(4'hC, d, r, o);
        check("out_unchanged", d, 32'h0000_00A5);
        do_write(4'h8, 32'h12, 4'h0, 1'b0, 1'b0, r, lat);
        check("nostrb_bresp", {30'b0, r}, 32'd0);
        do_read(4'h8, d, r, o);
        check("nostrb_taps", d, 32'h0000_00B8);

        // Back-pressure on B: the next AW must wait for the response
        do_write(4'h4, 32'h3C, 4'hF, 1'b0, 1'b1, r, lat);
        model_write(4'h4, 32'h3C, 4'hF);
        s_axil_awaddr = 4'h8; s_axil_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bhold_state", {29'b0, s_axil_bvalid, s_axil_awready, s_axil_wready}, 32'd4);
        end
        s_axil_bready = 1'b1; @(posedge clk); #1; s_axil_bready = 1'b0;
        check("bhold_released", {30'b0, s_axil_bvalid, s_axil_awready}, 32'd1);
        @(posedge clk); #1; s_axil_awvalid = 1'b0;
        s_axil_wdata = 32'h1D; s_axil_wstrb = 4'h1; s_axil_wvalid = 1'b1;
        cnt = 0;
        while (!s_axil_wready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        @(posedge clk); #1; s_axil_wvalid = 1'b0;
        cnt = 0;
        while (!s_axil_bvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
        check("second_bresp", {31'b0, s_axil_bvalid, s_axil_bresp} , 32'd4);
        s_axil_bready = 1'b1; @(posedge clk); #1; s_axil_bready = 1'b0;
        model_write(4'h8, 32'h1D, 4'h1);
        check("second_taps", {24'b0, lfsr_taps}, 32'h0000_001D);

        // Back-pressure on R: data must hold
        s_axil_araddr = 4'h4; s_axil_arvalid = 1'b1;
        cnt = 0;
        while (!s_axil_arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        @(posedge clk); #1; s_axil_arvalid = 1'b0;
        d0 = s_axil_rdata;
        check("rhold_first", {s_axil_rvalid, d0[30:0]}, 32'h8000_003C);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rhold_data", s_axil_rdata, 32'h0000_003C);
            check("rhold_valid", {31'b0, s_axil_rvalid}, 32'd1);
        end
        s_axil_rready = 1'b1; @(posedge clk); #1; s_axil_rready = 1'b0;

        // Reset while a write response is pending
        do_write(4'h4, 32'h77, 4'hF, 1'b0, 1'b1, r, lat);
        reset = 1'b1; #1;
        check("async_bvalid_drop", {31'b0, s_axil_bvalid}, 32'd0);
        check("async_regs", {14'b0, lfsr_stop, lfsr_start, lfsr_seed, lfsr_taps}, {18'b0, 8'h01, 8'hB8});
        @(posedge clk); #1; reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_write(4'h4, 32'h42, 4'hF, 1'b0, 1'b0, r, lat);
        model_write(4'h4, 32'h42, 4'hF);
        check("post_rst_bresp", {30'b0, r}, 32'd0);
        do_read(4'h4, d, r, o);
        check("post_rst_seed", d, 32'h0000_0042);

        // Random traffic against the register-array model
        for (int n = 0; n < 40; n++) begin
            a = 4'($urandom_range(0, 15));
            idx = int'(a) / 4;
            if ($urandom_range(0, 2) != 0) begin
                wd = $urandom;
                s  = 4'($urandom_range(0, 15));
                do_write(a, wd, s, 1'($urandom_range(0, 1)), 1'b0, r, lat);
                model_write(a, wd, s);
                check("rnd_bresp", {30'b0, r}, (idx == 3) ? 32'd2 : 32'd0);
                check("rnd_outputs", {14'b0, lfsr_stop, lfsr_start, lfsr_seed, lfsr_taps},
                      {14'b0, m_reg[0][1:0], m_reg[1], m_reg[2]});
            end else begin
                do_read(a, d, r, o);
                check("rnd_rdata", d, {24'b0, (idx == 3) ? o : m_reg[idx]});
                check("rnd_rresp", {30'b0, r}, 32'd0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lfsr_axil_regs.md
Name: lfsr_axil_regs

Overview:
AXI4-Lite slave register file that sits directly upstream of the 8-bit LFSR core. It holds the start, stop, seed and taps control registers and drives them to the LFSR. It also returns the live lfsr_out value to the bus master. It is one instance per LFSR, and the top-level wrapper connects the two.

Parameters:
ADDR_WIDTH, 4, byte-address width; only bits [3:2] are decoded and bits [1:0] are ignored.
DATA_WIDTH, 32, AXI-Lite data width; only byte lane 0 carries register data.
SEED_RST, 8'h01, reset value of the SEED register (non-zero, so the LFSR never locks up).
TAPS_RST, 8'hB8, reset value of the TAPS register (maximal-length 8-bit polynomial).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  DATA_WIDTH  write data
s_axil_wstrb  in  DATA_WIDTH/8  write byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
lfsr_start  out  1  to LFSR start
lfsr_stop  out  1  to LFSR stop
lfsr_seed  out  8  to LFSR seed
lfsr_taps  out  8  to LFSR taps, bit 7 maps to LFSR tap index 1
lfsr_out  in  8  from LFSR state

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Register map:
  - 0x0 CTRL (RW): bit0 = start, bit1 = stop, other bits read 0.
  - 0x4 SEED (RW): bits [7:0].
  - 0x8 TAPS (RW): bits [7:0].
  - 0xC OUT (RO): bits [7:0] = lfsr_out.
- Reset values: CTRL = 0, SEED = SEED_RST, TAPS = TAPS_RST. All valid/ready outputs are 0; bresp, rresp and rdata are 0.
- Control outputs are combinational copies of the registers. CTRL bits are level-held, not self-clearing, so software writes 0 to release them.
- Write address and data channels:
  - AW and W handshakes are independent and may arrive in any order or in the same cycle.
  - Each channel is latched into a holding register. awready is 1 when no AW is held and bvalid = 0; wready is the same rule for W.
  - The cycle after both AW and W are held: the write commits, bvalid rises, and both holding registers clear.
- Write response channel:
  - bvalid holds until bready. At most one write is outstanding.
  - After the B handshake, awready and wready return to 1 on the next cycle.
- Write rules:
  - wstrb[0] = 0: no register change, bresp = OKAY (2'b00).
  - Write to OUT: no effect, bresp = SLVERR (2'b10).
- Read channel:
  - arready = !rvalid.
  - On the AR handshake, rdata and rresp are registered and rvalid = 1 from the next cycle.
  - OUT returns lfsr_out as sampled in the AR handshake cycle.
  - rdata and rvalid hold stable until rready.
  - All addresses are valid for reads, so rresp = OKAY.
- Reads and writes proceed concurrently. A read of a register in the same cycle as a write commit to it returns the old value.
- Register lifetime: a register write is visible on the lfsr_* outputs the cycle after commit. The LFSR sees it on its next edge.
- Reset mid-transaction: all channel state is dropped and no response is issued.

Decomposition:
- Package lfsr_axil_pkg contains:
  - address constants ADDR_CTRL, ADDR_SEED, ADDR_TAPS, ADDR_OUT;
  - RESP_OKAY and RESP_SLVERR;
  - CTRL bit indices CTRL_START and CTRL_STOP.
- No sub-module. The top-level wrapper instantiates lfsr_axil_regs and the LFSR core side by side.

Test Plan:
1. Reset release -> read CTRL = 0x0, SEED = 0x01, TAPS = 0xB8, all with rresp = 0.
2. AW one cycle before W, writing 0xA5 to SEED -> bvalid on the cycle after W is accepted, bresp = 0, lfsr_seed = 0xA5 the next cycle.
3. Write CTRL = 0x1, then poll OUT twice -> the two reads differ (LFSR running). Write CTRL = 0x2 -> OUT reads the SEED value.
4. Write 0x55 to OUT -> bresp = 2'b10 and OUT is unchanged. Write TAPS with wstrb = 0 -> bresp = 0 and TAPS is unchanged.
5. Hold bready = 0 for 5 cycles after a write -> bvalid stays high, awready and wready stay 0, and a second AW is accepted only after B completes. Hold rready = 0 for 3 cycles -> rdata is stable.
6. Assert reset while bvalid = 1 -> bvalid drops immediately (asynchronously), registers return to reset values, and the next write completes normally.
